// File: rtl/clk_enable_gen.sv
// Multi-channel integer clock-enable generator with registered square-wave outputs.
// All channels share a phase origin at the last reset/load edge; a lock flag tracks settling.
module clk_enable_gen #(
   parameter int unsigned                         NUM_CLOCKS  = 2,
   parameter int unsigned                         DIV_WIDTH   = 16,
   parameter logic [NUM_CLOCKS*DIV_WIDTH-1:0]     INIT_DIV    = 32'h0002_0019,
   parameter int unsigned                         LOCK_CYCLES = 16
) (
   input  logic                              refclk,
   input  logic                              rst,
   input  logic                              cfg_load,
   input  logic [NUM_CLOCKS*DIV_WIDTH-1:0]   cfg_div,
   output logic [NUM_CLOCKS-1:0]             outclk,
   output logic [NUM_CLOCKS-1:0]             clk_en,
   output logic                              locked
);

   localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

   logic              load_c;
   logic [LOCK_W-1:0] lock_cnt;

   // Reset and reprogramming share one realignment path; rst selects the divisor source.
   assign load_c = rst | cfg_load;

   for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
      logic [DIV_WIDTH-1:0] div_q;
      logic [DIV_WIDTH-1:0] cnt;
      logic                 en_q;
      logic                 out_q;

      always_ff @(posedge refclk) begin
         if (load_c) begin
            div_q <= rst ? INIT_DIV[i*DIV_WIDTH +: DIV_WIDTH] : cfg_div[i*DIV_WIDTH +: DIV_WIDTH];
            cnt   <= '0;
            en_q  <= 1'b0;
            out_q <= 1'b0;
         end else if (div_q == '0) begin
            cnt   <= '0;
            en_q  <= 1'b0;
            out_q <= 1'b0;
         end else if (div_q == DIV_WIDTH'(1)) begin
            cnt   <= '0;
            en_q  <= 1'b1;
            out_q <= 1'b0;
         end else begin
            en_q  <= (cnt == '0);
            out_q <= (cnt < (div_q >> 1));
            cnt   <= (cnt == div_q - DIV_WIDTH'(1)) ? '0 : cnt + DIV_WIDTH'(1);
         end
      end

      assign clk_en[i] = en_q;
      assign outclk[i] = out_q;
   end

   // Saturating settle counter; locked rises on the edge the count reaches LOCK_CYCLES.
   always_ff @(posedge refclk) begin
      if (load_c) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (lock_cnt != LOCK_W'(LOCK_CYCLES)) begin
         lock_cnt <= lock_cnt + LOCK_W'(1);
         if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
            locked <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: table vectors plus model-driven sequences, all checked
// through an expected-value queue popped one cycle after each stimulus edge.
module tb_clk_enable_gen;

   localparam int unsigned NC   = 2;
   localparam int unsigned DW   = 16;
   localparam int unsigned LOCK = 16;
   localparam logic [31:0] INIT = 32'h0002_0019;

   typedef struct packed {
      logic [1:0] en;
      logic [1:0] out;
      logic       lk;
   } exp_t;

   typedef struct {
      logic        r;
      logic        l;
      logic [31:0] d;
      exp_t        e;
   } vec_t;

   logic          refclk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_load = 1'b0;
   logic [31:0]   cfg_div = '0;
   logic [NC-1:0] outclk;
   logic [NC-1:0] clk_en;
   logic          locked;

   exp_t  sb[$];
   int    compared = 0;
   int    mismatched = 0;
   int    step_no = 0;
   int    run_m = 0;
   int    div_m[2];
   string tag = "init";

   clk_enable_gen #(
      .NUM_CLOCKS (NC),
      .DIV_WIDTH  (DW),
      .INIT_DIV   (INIT),
      .LOCK_CYCLES(LOCK)
   ) dut (
      .refclk  (refclk),
      .rst     (rst),
      .cfg_load(cfg_load),
      .cfg_div (cfg_div),
      .outclk  (outclk),
      .clk_en  (clk_en),
      .locked  (locked)
   );

   always #5 refclk = ~refclk;

   // Expected outputs after run_m run edges since the last load, by phase arithmetic.
   function automatic exp_t model_exp();
      exp_t e;
      e = '0;
      for (int c = 0; c < 2; c++) begin
         if (run_m > 0 && div_m[c] == 1) begin
            e.en[c] = 1'b1;
         end else if (run_m > 0 && div_m[c] >= 2) begin
            int p;
            p = (run_m - 1) % div_m[c];
            e.en[c]  = (p == 0);
            e.out[c] = (p < div_m[c] / 2);
         end
      end
      e.lk = (run_m >= int'(LOCK));
      return e;
   endfunction

   function automatic vec_t mk(input logic r, input logic l, input logic [31:0] d,
                               input logic [1:0] en, input logic [1:0] out, input logic lk);
      vec_t v;
      v.r = r; v.l = l; v.d = d;
      v.e.en = en; v.e.out = out; v.e.lk = lk;
      return v;
   endfunction

   task automatic check_one();
      exp_t e;
      if (sb.size() == 0) return;
      e = sb.pop_front();
      compared++;
      if (clk_en !== e.en) begin
         mismatched++;
         $display("FAIL %s step %0d clk_en got %b want %b", tag, step_no, clk_en, e.en);
      end
      compared++;
      if (outclk !== e.out) begin
         mismatched++;
         $display("FAIL %s step %0d outclk got %b want %b", tag, step_no, outclk, e.out);
      end
      compared++;
      if (locked !== e.lk) begin
         mismatched++;
         $display("FAIL %s step %0d locked got %b want %b", tag, step_no, locked, e.lk);
      end
   endtask

   task automatic step(input logic r, input logic l, input logic [31:0] d,
                       input bit use_v, input exp_t ve);
      @(negedge refclk);
      check_one();
      step_no++;
      rst = r;
      cfg_load = l;
      cfg_div = d;
      if (r) begin
         div_m[0] = int'(INIT[15:0]);
         div_m[1] = int'(INIT[31:16]);
         run_m = 0;
      end else if (l) begin
         div_m[0] = int'(d[15:0]);
         div_m[1] = int'(d[31:16]);
         run_m = 0;
      end else begin
         run_m++;
      end
      sb.push_back(use_v ? ve : model_exp());
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0, '0);
   endtask

   initial begin
      vec_t tbl[12];
      tbl[0]  = mk(1'b0, 1'b1, 32'h0002_0003, 2'b00, 2'b00, 1'b0);
      tbl[1]  = mk(1'b0, 1'b0, 32'h0,         2'b11, 2'b11, 1'b0);
      tbl[2]  = mk(1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0);
      tbl[3]  = mk(1'b0, 1'b0, 32'h0,         2'b10, 2'b10, 1'b0);
      tbl[4]  = mk(1'b0, 1'b0, 32'h0,         2'b01, 2'b01, 1'b0);
      tbl[5]  = mk(1'b0, 1'b0, 32'h0,         2'b10, 2'b10, 1'b0);
      tbl[6]  = mk(1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0);
      tbl[7]  = mk(1'b1, 1'b1, 32'h0000_0007, 2'b00, 2'b00, 1'b0);
      tbl[8]  = mk(1'b0, 1'b0, 32'h0,         2'b11, 2'b11, 1'b0);
      tbl[9]  = mk(1'b0, 1'b1, 32'h0000_0001, 2'b00, 2'b00, 1'b0);
      tbl[10] = mk(1'b0, 1'b0, 32'h0,         2'b01, 2'b00, 1'b0);
      tbl[11] = mk(1'b0, 1'b0, 32'h0,         2'b01, 2'b00, 1'b0);

      tag = "reset_defaults";
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b0, '0);
      run(60);

      tag = "table";
      for (int i = 0; i < 12; i++) step(tbl[i].r, tbl[i].l, tbl[i].d, 1'b1, tbl[i].e);

      tag = "div1_div0_lock";
      run(20);

      tag = "rst_over_load";
      step(1'b1, 1'b1, 32'h0000_0007, 1'b0, '0);
      run(60);

      tag = "midperiod_load";
      run(5);
      step(1'b0, 1'b1, 32'h0002_0004, 1'b0, '0);
      run(30);

      tag = "max_div";
      step(1'b0, 1'b1, 32'h0002_FFFF, 1'b0, '0);
      run(65540);

      @(negedge refclk);
      check_one();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
